stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Stopwatch core that consumes the 1-clk hundrethSec pulse from the clock divider.
//  Counts elapsed time in BCD as mm:ss.hh (00:00.00 to 59:59.99).
//  Two push-buttons control it: start_stop and lap_clr. Outputs drive the 7-seg decoders.
//  Sits between the divider (upstream) and the display decode (downstream).
// PARAMETERS
//  SYNC_STAGES  2   flops in each button synchronizer; legal range 2..4
// PORTS
//  clk          in   1  system clock, 50MHz
//  rst_n        in   1  asynch active low reset
//  hundrethSec  in   1  1-clk tick, one every 1/100 sec (any spacing >= 1 clk legal)
//  start_stop   in   1  async button, active high, level
//  lap_clr      in   1  async button, active high, level
//  running      out  1  1 when state is RUNNING or LAP
//  lap_active   out  1  1 when state is LAP (display frozen)
//  wrap         out  1  sticky; set when count rolls 59:59.99 -> 00:00.00
//  min_tens     out  4  BCD 0..5
//  min_ones     out  4  BCD 0..9
//  sec_tens     out  4  BCD 0..5
//  sec_ones     out  4  BCD 0..9
//  hund_tens    out  4  BCD 0..9
//  hund_ones    out  4  BCD 0..9
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=CLEARED; count=0; lap reg=0; all outputs 0; sync flops 0.
//  - Buttons: each passes through a SYNC_STAGES-flop sync, then a rising-edge detect.
//    Button first sampled high at edge k -> state updates at edge k+SYNC_STAGES.
//    Held button = one event. Release produces no event.
//  - FSM on edge events ss/lc (ss has priority; on a same-cycle ss+lc, lc is dropped):
//      CLEARED: ss -> RUNNING; lc -> no effect
//      RUNNING: ss -> STOPPED; lc -> LAP, lap reg <= live count (same edge)
//      LAP:     ss -> STOPPED (display returns live); lc -> RUNNING (display returns live)
//      STOPPED: ss -> RUNNING (resume); lc -> CLEARED, count <= 0, wrap <= 0
//  - Count increments on an edge where hundrethSec=1 AND the pre-edge state is RUNNING or LAP.
//    A tick on the same edge as a state change is governed by the pre-edge state.
//  - Carry chain: hund_ones 9->0 carries into hund_tens; hund 99->00 carries into sec_ones;
//    sec 59->00 carries into min; min 59->00 at 59:59.99 wraps all digits to 0 and sets wrap.
//    Counting continues after a wrap. Digits never hold non-BCD values.
//  - Display mux: LAP shows the lap register; every other state shows the live count.
//    Outputs come from registers plus a mux on registered state only, with no comb path
//    from input ports. running, lap_active and wrap are registered or decoded from state.
//  - lc in CLEARED is a no-op. ss in STOPPED does not clear the count.
// STRUCTURE
//  - stopwatch_pkg: typedef enum logic [1:0] {CLEARED, RUNNING, STOPPED, LAP} sw_state_t;
//    typedef logic [3:0] bcd_t; localparams HUND_MOD=10, TENS6_MOD=6.
//  - Sub-module bcd_digit #(MOD): one BCD digit with clk, rst_n, clr, inc;
//    outputs q (bcd_t) and carry = inc & (q==MOD-1). Six instances are chained.
//  - Sync and edge detect stay inline: a generate loop over SYNC_STAGES, two copies.
// TESTING
//  1 Reset: rst_n=0 mid-run, no clk edge -> all digits 0, running=0, wrap=0 immediately.
//  2 Run: ss, then 150 ticks -> 00:01.50, running=1; ss, then 20 ticks -> still 00:01.50.
//  3 Lap: at 00:01.50 press lc, 25 ticks -> display 00:01.50, lap_active=1;
//    lc again -> 00:01.75.
//  4 Wrap: run, 359999 back-to-back ticks -> 59:59.99; 1 more -> 00:00.00, wrap=1;
//    ss, then lc -> wrap=0.
//  5 Collision: in RUNNING, ss and lc edges on the same cycle -> STOPPED, lap_active=0.
//    Tick on that same edge -> counted (+1).
//  6 Clear: STOPPED at 00:03.07, lc -> CLEARED, 00:00.00; 10 ticks -> still 00:00.00.
//    Held ss for 100 clks -> exactly one transition.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit moduli for the stopwatch core
package stopwatch_pkg;

  typedef enum logic [1:0] {CLEARED, RUNNING, STOPPED, LAP} sw_state_t;
  typedef logic [3:0] bcd_t;

  localparam int HUND_MOD  = 10;
  localparam int TENS6_MOD = 6;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit counting 0..MOD-1 with ripple carry out
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = HUND_MOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  logic at_max;

  assign at_max = (q == bcd_t'(MOD - 1));
  assign carry  = inc & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss.hh stopwatch with start/stop and lap/clear buttons
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hundrethSec,
  input  logic start_stop,
  input  logic lap_clr,
  output logic running,
  output logic lap_active,
  output logic wrap,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output bcd_t hund_tens,
  output bcd_t hund_ones
);

  // Bit 0 carries start_stop, bit 1 carries lap_clr through the synchronizer.
  logic [1:0] btn_sync [SYNC_STAGES];
  logic [1:0] btn_prev;

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        btn_sync[i] <= '0;
      end else if (i == 0) begin
        btn_sync[i] <= {lap_clr, start_stop};
      end else begin
        btn_sync[i] <= btn_sync[(i == 0) ? 0 : i - 1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn_sync[SYNC_STAGES-1];
    end
  end

  logic ss_evt, lc_evt;
  assign ss_evt = btn_sync[SYNC_STAGES-1][0] & ~btn_prev[0];
  assign lc_evt = btn_sync[SYNC_STAGES-1][1] & ~btn_prev[1];

  sw_state_t state, state_nxt;
  logic      lap_load, clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEARED;
    end else begin
      state <= state_nxt;
    end
  end

  // start_stop wins a same-cycle collision; the lap_clr event is simply dropped.
  always_comb begin
    state_nxt = state;
    lap_load  = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      CLEARED: if (ss_evt) state_nxt = RUNNING;
      RUNNING: begin
        if (ss_evt) begin
          state_nxt = STOPPED;
        end else if (lc_evt) begin
          state_nxt = LAP;
          lap_load  = 1'b1;
        end
      end
      LAP: begin
        if (ss_evt)      state_nxt = STOPPED;
        else if (lc_evt) state_nxt = RUNNING;
      end
      STOPPED: begin
        if (ss_evt) begin
          state_nxt = RUNNING;
        end else if (lc_evt) begin
          state_nxt = CLEARED;
          clr_cnt   = 1'b1;
        end
      end
      default: state_nxt = CLEARED;
    endcase
  end

  logic counting, tick;
  assign counting = (state == RUNNING) || (state == LAP);
  assign tick     = hundrethSec & counting;

  bcd_t d_ho, d_ht, d_so, d_st, d_mo, d_mt;
  logic c_ho, c_ht, c_so, c_st, c_mo, c_mt;

  bcd_digit #(.MOD(HUND_MOD))  u_hund_ones (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(tick), .q(d_ho), .carry(c_ho));
  bcd_digit #(.MOD(HUND_MOD))  u_hund_tens (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c_ho), .q(d_ht), .carry(c_ht));
  bcd_digit #(.MOD(HUND_MOD))  u_sec_ones  (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c_ht), .q(d_so), .carry(c_so));
  bcd_digit #(.MOD(TENS6_MOD)) u_sec_tens  (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c_so), .q(d_st), .carry(c_st));
  bcd_digit #(.MOD(HUND_MOD))  u_min_ones  (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c_st), .q(d_mo), .carry(c_mo));
  bcd_digit #(.MOD(TENS6_MOD)) u_min_tens  (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c_mo), .q(d_mt), .carry(c_mt));

  logic [23:0] live, lap_q, disp;
  assign live = {d_mt, d_mo, d_st, d_so, d_ht, d_ho};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= '0;
      wrap  <= 1'b0;
    end else begin
      if (lap_load) lap_q <= live;
      if (clr_cnt)   wrap <= 1'b0;
      else if (c_mt) wrap <= 1'b1;
    end
  end

  assign disp       = (state == LAP) ? lap_q : live;
  assign running    = counting;
  assign lap_active = (state == LAP);
  assign {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones} = disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with directed vectors
module tb_stopwatch_ctrl;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n, hundrethSec, start_stop, lap_clr;
  logic running, lap_active, wrap;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .hundrethSec(hundrethSec),
    .start_stop(start_stop), .lap_clr(lap_clr),
    .running(running), .lap_active(lap_active), .wrap(wrap),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .hund_tens(hund_tens), .hund_ones(hund_ones)
  );

  typedef struct {
    string       name;
    logic [23:0] digits;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_now(input string nm, input logic [23:0] d,
                            input logic r, input logic l, input logic w);
    exp_t e;
    e.name   = nm;
    e.digits = d;
    e.flags  = {r, l, w};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [23:0] got_d;
    logic [2:0]  got_f;
    while (sb.size() > 0) begin
      e     = sb.pop_front();
      got_d = {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones};
      got_f = {running, lap_active, wrap};
      n_checks++;
      if (got_d === e.digits) n_pass++;
      else $display("FAIL %s digits got %h want %h", e.name, got_d, e.digits);
      n_checks++;
      if (got_f === e.flags) n_pass++;
      else $display("FAIL %s run/lap/wrap got %b want %b", e.name, got_f, e.flags);
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    hundrethSec = 1'b1;
    repeat (n) clk1();
    hundrethSec = 1'b0;
  endtask

  task automatic press_ss();
    start_stop = 1'b1;
    repeat (S + 1) clk1();
    start_stop = 1'b0;
    repeat (S + 1) clk1();
  endtask

  task automatic press_lc();
    lap_clr = 1'b1;
    repeat (S + 1) clk1();
    lap_clr = 1'b0;
    repeat (S + 1) clk1();
  endtask

  initial begin
    rst_n = 1'b0; hundrethSec = 1'b0; start_stop = 1'b0; lap_clr = 1'b0;
    repeat (3) clk1();
    expect_now("reset", 24'h000000, 0, 0, 0);
    clk1();
    rst_n = 1'b1;
    clk1();

    press_ss();
    expect_now("run_start", 24'h000000, 1, 0, 0);
    ticks(150);
    expect_now("run_150", 24'h000150, 1, 0, 0);
    press_ss();
    expect_now("stop", 24'h000150, 0, 0, 0);
    ticks(20);
    expect_now("stop_hold", 24'h000150, 0, 0, 0);

    press_ss();
    press_lc();
    expect_now("lap_enter", 24'h000150, 1, 1, 0);
    ticks(25);
    expect_now("lap_frozen", 24'h000150, 1, 1, 0);
    press_lc();
    expect_now("lap_exit", 24'h000175, 1, 0, 0);

    ticks(132);
    expect_now("run_307", 24'h000307, 1, 0, 0);
    press_ss();
    expect_now("stop_307", 24'h000307, 0, 0, 0);
    press_lc();
    expect_now("clear", 24'h000000, 0, 0, 0);
    ticks(10);
    expect_now("clear_hold", 24'h000000, 0, 0, 0);
    press_lc();
    ticks(10);
    expect_now("lc_in_cleared", 24'h000000, 0, 0, 0);

    start_stop = 1'b1;
    repeat (100) clk1();
    start_stop = 1'b0;
    repeat (S + 1) clk1();
    ticks(5);
    expect_now("held_ss", 24'h000005, 1, 0, 0);

    // Both buttons land on the same edge together with a tick.
    start_stop = 1'b1; lap_clr = 1'b1;
    repeat (S) clk1();
    hundrethSec = 1'b1;
    clk1();
    hundrethSec = 1'b0;
    expect_now("collide", 24'h000006, 0, 0, 0);
    start_stop = 1'b0; lap_clr = 1'b0;
    repeat (S + 1) clk1();
    ticks(10);
    expect_now("collide_stopped", 24'h000006, 0, 0, 0);

    press_lc();
    press_ss();
    ticks(359999);
    expect_now("pre_wrap", 24'h595999, 1, 0, 0);
    ticks(1);
    expect_now("wrap", 24'h000000, 1, 0, 1);
    ticks(3);
    expect_now("wrap_sticky", 24'h000003, 1, 0, 1);
    press_ss();
    expect_now("wrap_stop", 24'h000003, 0, 0, 1);
    press_lc();
    expect_now("wrap_clear", 24'h000000, 0, 0, 0);

    press_ss();
    ticks(7);
    expect_now("pre_reset", 24'h000007, 1, 0, 0);
    clk1();
    hundrethSec = 1'b1;
    rst_n = 1'b0;
    #1;
    expect_now("async_reset", 24'h000000, 0, 0, 0);
    clk1();
    hundrethSec = 1'b0;
    rst_n = 1'b1;
    clk1();
    ticks(4);
    expect_now("post_reset", 24'h000000, 0, 0, 0);

    repeat (3) clk1();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
